// File: rtl/ship_placement_ctrl.sv
// Ship placement stage: cursor movement, per-cell bounds/overlap check and occupancy write.
// Optional SHIP_PREVIEW_EN builds the combinational ship-footprint preview output.
module ship_placement_ctrl #(
    parameter int N         = 5,
    parameter int MAX_SHIPS = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [2:0]     ships_amount,
    input  logic           move_up,
    input  logic           move_down,
    input  logic           move_left,
    input  logic           move_right,
    input  logic           rotate,
    input  logic           place,
    output logic [2:0]     i_actual,
    output logic [2:0]     j_actual,
    output logic [N*N-1:0] board,
    output logic [2:0]     ships_placed,
    output logic           ships_located,
    output logic           place_error,
    output logic           busy,
    output logic [N*N-1:0] preview
);
    localparam int IW = $clog2(N*N);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_CHECK, S_WRITE, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [5:0]     r_btn_d;
    logic [2:0]     r_i, r_j, r_idx, r_placed, r_target;
    logic           r_vert, r_latched, r_located, r_err, r_inc;
    logic [N*N-1:0] r_board;

    logic [5:0]     w_btn, w_edge;
    logic [3:0]     w_size, w_off, w_row, w_col, w_end;
    logic [2:0]     w_amt, w_tgt;
    logic [IW-1:0]  w_cell;
    logic           w_oob, w_hit, w_last, w_final, w_place_go;

    assign w_btn  = {rotate, place, move_right, move_left, move_down, move_up};
    assign w_edge = w_btn & ~r_btn_d;

    assign w_size = {1'b0, r_placed} + 4'd1;
    assign w_off  = {1'b0, r_idx};
    assign w_row  = {1'b0, r_i} + (r_vert ? w_off : 4'd0);
    assign w_col  = {1'b0, r_j} + (r_vert ? 4'd0 : w_off);
    assign w_end  = (r_vert ? {1'b0, r_i} : {1'b0, r_j}) + w_size - 4'd1;
    assign w_oob  = (r_idx == 3'd0) && (w_end > 4'(N-1));
    assign w_cell = IW'(32'(w_row) * N + 32'(w_col));
    // Cell 0 is the cursor itself, so the index is always in range when read.
    assign w_hit  = r_board[w_cell];
    assign w_last = (w_off == w_size - 4'd1);

    assign w_amt = (ships_amount == 3'd0) ? 3'd1 :
                   (ships_amount > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS) : ships_amount;
    assign w_tgt   = r_latched ? r_target : w_amt;
    assign w_final = (r_placed + 3'd1 == w_tgt);
    // Hold off a new placement while the previous count update is still pending.
    assign w_place_go = w_edge[4] && !r_inc;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable && !r_located) w_next = S_MOVE;
            S_MOVE:  if (!enable) w_next = S_IDLE;
                     else if (w_place_go) w_next = S_CHECK;
            S_CHECK: if (!enable) w_next = S_IDLE;
                     else if (w_oob || w_hit) w_next = S_MOVE;
                     else if (w_last) w_next = S_WRITE;
            S_WRITE: if (w_last) w_next = w_final ? S_DONE : (enable ? S_MOVE : S_IDLE);
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state == S_CHECK) || (r_state == S_WRITE);
        place_error   = r_err;
        i_actual      = r_i;
        j_actual      = r_j;
        board         = r_board;
        ships_placed  = r_placed;
        ships_located = r_located;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_d <= '0; r_i <= '0; r_j <= '0; r_idx <= '0; r_placed <= '0;
            r_target <= '0; r_vert <= 1'b0; r_latched <= 1'b0; r_located <= 1'b0;
            r_err <= 1'b0; r_inc <= 1'b0; r_board <= '0;
        end else begin
            r_btn_d <= w_btn;
            r_err   <= 1'b0;
            r_inc   <= 1'b0;
            if (r_inc) begin
                r_placed  <= r_placed + 3'd1;
                r_located <= (r_placed + 3'd1 == r_target);
            end
            case (r_state)
                S_MOVE: begin
                    r_idx <= '0;
                    if (enable) begin
                        if (w_edge[5]) r_vert <= ~r_vert;
                        if (w_place_go && !r_latched) begin
                            r_target  <= w_amt;
                            r_latched <= 1'b1;
                        end
                        // A place edge swallows any move edge in the same cycle.
                        if (!w_edge[4]) begin
                            if (w_edge[0])      begin if (r_i != 3'd0)      r_i <= r_i - 3'd1; end
                            else if (w_edge[1]) begin if (r_i != 3'(N-1))   r_i <= r_i + 3'd1; end
                            else if (w_edge[2]) begin if (r_j != 3'd0)      r_j <= r_j - 3'd1; end
                            else if (w_edge[3]) begin if (r_j != 3'(N-1))   r_j <= r_j + 3'd1; end
                        end
                    end
                end
                S_CHECK: if (enable) begin
                    if (w_oob || w_hit) r_err <= 1'b1;
                    else                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                end
                S_WRITE: begin
                    r_board[w_cell] <= 1'b1;
                    r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                    if (w_last) r_inc <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIP_PREVIEW_EN
    always_comb begin
        preview = '0;
        if (r_state == S_MOVE) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (r_vert ? (c == int'(r_j) && r >= int'(r_i) && r < int'(r_i) + int'(w_size))
                               : (r == int'(r_i) && c >= int'(r_j) && c < int'(r_j) + int'(w_size)))
                        preview[r*N+c] = 1'b1;
                end
            end
        end
    end
`else
    assign preview = '0;
`endif

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Scoreboard bench for ship_placement_ctrl: a board/cursor model predicts each placement outcome.
module tb_ship_placement_ctrl;
    localparam int N = 5;

    logic           clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic [2:0]     ships_amount = 3'd0;
    logic           move_up = 0, move_down = 0, move_left = 0, move_right = 0, rotate = 0, place = 0;
    logic [2:0]     i_actual, j_actual, ships_placed;
    logic [N*N-1:0] board, preview;
    logic           ships_located, place_error, busy;

    ship_placement_ctrl #(.N(N), .MAX_SHIPS(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ships_amount(ships_amount),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .rotate(rotate), .place(place), .i_actual(i_actual), .j_actual(j_actual), .board(board),
        .ships_placed(ships_placed), .ships_located(ships_located), .place_error(place_error),
        .busy(busy), .preview(preview)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           err;
        int             lat;
        int             bsy;
        logic [N*N-1:0] brd;
        int             cnt;
        logic           loc;
    } exp_t;

    exp_t           sb[$];
    int             n_chk = 0, n_err = 0;
    logic [N*N-1:0] m_board = '0;
    int             m_cnt = 0, m_i = 0, m_j = 0;
    logic           m_vert = 1'b0, m_live = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N*N-1:0] fp(input int i, input int j, input logic v, input int s);
        logic [N*N-1:0] m;
        m = '0;
        for (int k = 0; k < s; k++) begin
            int r, c;
            r = i + (v ? k : 0);
            c = j + (v ? 0 : k);
            if (r < N && c < N) m[r*N+c] = 1'b1;
        end
        return m;
    endfunction

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic ro);
        @(negedge clk);
        move_up = u; move_down = d; move_left = l; move_right = r; rotate = ro;
        @(negedge clk);
        move_up = 0; move_down = 0; move_left = 0; move_right = 0; rotate = 0;
        if (m_live) begin
            if (ro) m_vert = ~m_vert;
            if (u)      m_i = (m_i > 0) ? m_i - 1 : 0;
            else if (d) m_i = (m_i < N-1) ? m_i + 1 : N-1;
            else if (l) m_j = (m_j > 0) ? m_j - 1 : 0;
            else if (r) m_j = (m_j < N-1) ? m_j + 1 : N-1;
        end
        chk("cur_i", i_actual, m_i);
        chk("cur_j", j_actual, m_j);
    endtask

    task automatic place_op(input logic ro, input logic mv);
        exp_t           e, g;
        int             s, endc, hit, lat, bc;
        logic           got, oob;
        logic [N*N-1:0] m;
        logic [2:0]     pc;
        if (ro) m_vert = ~m_vert;
        s    = m_cnt + 1;
        endc = (m_vert ? m_i : m_j) + s - 1;
        oob  = endc > N-1;
        hit  = -1;
        m    = fp(m_i, m_j, m_vert, s);
        if (!oob)
            for (int k = 0; k < s; k++) begin
                int r, c;
                r = m_i + (m_vert ? k : 0);
                c = m_j + (m_vert ? 0 : k);
                if (hit < 0 && m_board[r*N+c]) hit = k;
            end
        e.err = oob || (hit >= 0);
        e.lat = oob ? 1 : (hit >= 0 ? hit + 1 : 2*s + 1);
        e.bsy = e.err ? e.lat : 2*s;
        if (!e.err) begin
            m_board = m_board | m;
            m_cnt++;
        end
        e.brd = m_board;
        e.cnt = m_cnt;
        e.loc = (m_cnt == 3);
        sb.push_back(e);

        pc = ships_placed; got = 0; lat = 0; bc = 0;
        @(negedge clk);
        place = 1; rotate = ro; move_right = mv;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 0) begin place = 0; rotate = 0; move_right = 0; end
            if (busy) bc++;
            if (place_error || ships_placed != pc) begin got = 1; lat = k; end
        end
        chk("place_done", got, 1);
        g = sb.pop_front();
        chk("place_err", place_error, g.err);
        chk("latency", lat, g.lat);
        chk("busy_cycles", bc, g.bsy);
        chk("board", board, g.brd);
        chk("count", ships_placed, g.cnt);
        chk("located", ships_located, g.loc);
        if (g.err) begin
            @(negedge clk);
            chk("err_pulse", place_error, 0);
        end
        chk("cur_i", i_actual, m_i);
        chk("cur_j", j_actual, m_j);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_i", i_actual, 0);
        chk("rst_j", j_actual, 0);
        chk("rst_board", board, 0);
        chk("rst_count", ships_placed, 0);
        chk("rst_located", ships_located, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", place_error, 0);
        chk("rst_preview", preview, 0);

        rst = 1; enable = 1; ships_amount = 3; m_live = 1;
        repeat (2) @(negedge clk);
        chk("start_i", i_actual, 0);
        chk("start_j", j_actual, 0);
        chk("start_board", board, 0);

        place_op(0, 0);                    // size 1 at (0,0)
        ships_amount = 5;                  // target already latched at 3
        press(0, 0, 0, 1, 0);
        place_op(0, 0);                    // size 2 at (0,1)
        place_op(1, 0);                    // size 3 vertical at (0,1): collision
        for (int k = 0; k < 3; k++) press(0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 1);
        place_op(0, 0);                    // size 3 horizontal at (0,4): out of bounds
        for (int k = 0; k < 10; k++) press(0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) press(1, 0, 0, 0, 0);
        press(0, 1, 1, 1, 0);              // down wins over left/right
        press(0, 0, 0, 0, 1);              // vertical

        // Enable drop during CHECK aborts with no write.
        @(negedge clk); place = 1;
        @(negedge clk); place = 0; enable = 0;
        chk("abort_busy_chk", busy, 1);
        repeat (4) @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_board", board, m_board);
        chk("abort_count", ships_placed, m_cnt);
        chk("abort_perr", place_error, 0);
        enable = 1;
        repeat (2) @(negedge clk);
`ifdef SHIP_PREVIEW_EN
        chk("preview", preview, fp(m_i, m_j, m_vert, m_cnt + 1));
`else
        chk("preview", preview, 0);
`endif

        place_op(0, 1);                    // size 3 vertical at (1,0), right edge dropped

        m_live = 0;
        press(0, 0, 0, 1, 0);
        @(negedge clk); place = 1;
        @(negedge clk); place = 0;
        repeat (4) @(negedge clk);
        chk("done_busy", busy, 0);
        chk("done_board", board, m_board);
        chk("done_located", ships_located, 1);
        chk("done_preview", preview, 0);

        rst = 0;
        repeat (2) @(negedge clk);
        chk("rst2_board", board, 0);
        chk("rst2_count", ships_placed, 0);
        chk("rst2_located", ships_located, 0);
        chk("rst2_i", i_actual, 0);
        chk("rst2_j", j_actual, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
